// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam int         FRAME_LEN = 11;

  // Odd parity over data plus parity bit must come out as 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded byte / key event bundle presented to the keyboard consumer.
interface ps2_keyboard_rx_if;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       parity_err;
  logic       frame_err;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;

  modport master (
    output byte_valid, rx_byte, parity_err, frame_err,
           key_valid, key_code, key_ext, key_break
  );

  modport slave (
    input  byte_valid, rx_byte, parity_err, frame_err,
           key_valid, key_code, key_ext, key_break
  );
endinterface

// File: rtl/ps2_keyboard_rx_pin_filter.sv
// Pin synchroniser with optional level filter and falling-edge strobe.
module ps2_pin_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 8,
  parameter bit   FILTER_EN   = 1'b1,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic filt_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_EN) begin : g_filt
      localparam int CW = $clog2(FILT_LEN + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          filt_q, filt_d;
      logic          fall_q, fall_d;

      // Count consecutive samples disagreeing with the filtered level;
      // any agreeing sample restarts the count.
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_o != filt_q) begin
          if (cnt_q == CNT_MAX) filt_d = sync_o;
          else                  cnt_d  = cnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b1;
          fall_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
          fall_q <= fall_d;
        end
      end

      assign filt_o = filt_q;
      assign fall_o = fall_q;
    end else begin : g_nofilt
      assign filt_o = sync_o;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame deserialiser, checker and E0/F0 prefix folding.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PS2_CLK,
  input  logic              PS2_DAT,
  ps2_keyboard_rx_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic clk_sync_unused, clk_filt_unused, fall;
  logic dat, dat_filt_unused, dat_fall_unused;

  ps2_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .FILTER_EN(1'b1))
    u_clk_filt (.clk(CLK), .rst_n(RST_N), .pin_i(PS2_CLK),
                .sync_o(clk_sync_unused), .filt_o(clk_filt_unused), .fall_o(fall));

  ps2_pin_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .FILTER_EN(1'b0))
    u_dat_sync (.clk(CLK), .rst_n(RST_N), .pin_i(PS2_DAT),
                .sync_o(dat), .filt_o(dat_filt_unused), .fall_o(dat_fall_unused));

  // Frame FSM
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    to_cnt_d     = '0;
    byte_valid_d = 1'b0;
    rx_byte_d    = rx_byte_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q != IDLE && !fall) to_cnt_d = to_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: if (fall && !dat) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fall) begin
        shift_d   = {dat, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = dat;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (!odd_parity_ok(shift_q, par_q)) parity_err_d = 1'b1;
        else if (!dat)                      frame_err_d  = 1'b1;
        else begin
          byte_valid_d = 1'b1;
          rx_byte_d    = shift_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; the partial byte is never published.
    if (state_q != IDLE && !fall && to_cnt_q == TO_MAX) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      rx_byte_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      rx_byte_q    <= rx_byte_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Prefix decoder
  logic       ext_pend_q, ext_pend_d;
  logic       break_pend_q, break_pend_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_break_q, key_break_d;

  always_comb begin
    ext_pend_d   = ext_pend_q;
    break_pend_d = break_pend_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;

    if (parity_err_q || frame_err_q) begin
      ext_pend_d   = 1'b0;
      break_pend_d = 1'b0;
    end else if (byte_valid_q) begin
      if (rx_byte_q == SC_BREAK)    break_pend_d = 1'b1;
      else if (rx_byte_q == SC_EXT) ext_pend_d   = 1'b1;
      else begin
        key_valid_d  = 1'b1;
        key_code_d   = rx_byte_q;
        key_ext_d    = ext_pend_q;
        key_break_d  = break_pend_q;
        ext_pend_d   = 1'b0;
        break_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ext_pend_q   <= 1'b0;
      break_pend_q <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
    end else begin
      ext_pend_q   <= ext_pend_d;
      break_pend_q <= break_pend_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
    end
  end

  assign rx.byte_valid = byte_valid_q;
  assign rx.rx_byte    = rx_byte_q;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.key_valid  = key_valid_q;
  assign rx.key_code   = key_code_q;
  assign rx.key_ext    = key_ext_q;
  assign rx.key_break  = key_break_q;

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Receives PS/2 keyboard frames from the PS2_CLK/PS2_DAT pins and turns them into decoded key events for MAIN, which feeds them to the HEX display and control logic. It sits directly upstream of MAIN's keyboard consumer. The block synchronises and deglitches the pins, deserialises each 11-bit frame, and checks parity and the stop bit. It then folds the E0 (extended) and F0 (break) prefixes into one key event per scan code.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each pin synchroniser (minimum 2)
FILT_LEN, 8, consecutive identical CLK samples required before the filtered PS2_CLK level changes
TIMEOUT_CYCLES, 50000, CLK cycles with no PS2_CLK falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
CLK  input  1  system clock, 50 MHz
RST_N  input  1  asynchronous active-low reset
PS2_CLK  input  1  raw PS/2 clock pin, asynchronous, idle high
PS2_DAT  input  1  raw PS/2 data pin, asynchronous
byte_valid  output  1  one-cycle pulse: rx_byte holds a good frame
rx_byte  output  8  last good received byte
parity_err  output  1  one-cycle pulse: odd parity failed
frame_err  output  1  one-cycle pulse: stop bit was 0, or the frame timed out
key_valid  output  1  one-cycle pulse: key event ready
key_code  output  8  scan code of the event (prefixes stripped)
key_ext  output  1  event was prefixed by E0
key_break  output  1  event was prefixed by F0 (key release)

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; all outputs 0; pending flags and timeout counter cleared; filtered clock preset to 1.
- Pin conditioning: SYNC_STAGES-FF synchroniser on each pin.
  - Filtered clock toggles only after FILT_LEN equal consecutive synchronised samples; shorter glitches are ignored.
  - fall = 1-cycle strobe when the filtered clock goes 1->0. Data is sampled from the synchronised PS2_DAT on fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA with bit count 0. On fall with data=1, stay in IDLE; no error.
  - DATA: on each fall, shift the bit in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the bit. Go to STOP.
  - STOP: on fall, check the frame and return to IDLE.
- Frame checks, applied on the STOP fall:
  - XOR of the 8 data bits and the parity bit must be 1. If not, pulse parity_err; no byte_valid.
  - Otherwise, if the stop bit is 0, pulse frame_err; no byte_valid.
  - Otherwise, pulse byte_valid and update rx_byte.
  - All of these pulse the cycle after the STOP fall strobe.
- Timeout: in any non-IDLE state the counter increments each cycle and clears on fall. At TIMEOUT_CYCLES, go to IDLE and pulse frame_err. A partial byte never reaches rx_byte.
- Decoder, acting on byte_valid:
  - F0 sets break_pend.
  - E0 sets ext_pend.
  - Any other byte: the next cycle, pulse key_valid with key_code=byte, key_ext=ext_pend, key_break=break_pend, then clear both pending flags.
  - key_code, key_ext and key_break hold until the next key_valid.
  - parity_err or frame_err clears both pending flags.
- Latency: key_valid follows byte_valid by exactly 1 cycle. byte_valid follows the stop-bit fall by 1 cycle. Pin-to-fall delay is SYNC_STAGES+FILT_LEN cycles.
- No backpressure: consumers must capture pulses. Pulses are at least 11 PS/2 bit times apart.
- Host-to-device transmission is out of scope. PS2_CLK/PS2_DAT are never driven.

Decomposition:
- Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP); constants SC_BREAK=8'hF0, SC_EXT=8'hE0; frame length 11.
- Sub-module ps2_pin_filter: synchroniser, glitch filter and fall strobe. Instanced once for the clock; the data line uses only its synchroniser path.

Test Plan:
- Reset, then frame 0x1C (data 00111000 LSB-first, parity 0, stop 1) -> byte_valid with rx_byte=0x1C; next cycle key_valid, key_code=0x1C, ext=0, break=0.
- Frames F0 (parity 1), then 1C -> only one key_valid: code 0x1C, break=1, ext=0. The F0 frame produces byte_valid but no key_valid.
- Frames E0 (parity 0), F0, 75 (parity 0) -> one key_valid: code 0x75, ext=1, break=1. A following 1C -> ext=0, break=0.
- Frame 0x1C with parity bit 1 -> parity_err pulse; no byte_valid or key_valid. Frame 0x1C with stop bit 0 -> frame_err pulse only.
- Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES+10 -> one frame_err pulse and FSM back in IDLE. A following good 0x1C frame decodes correctly.
- A PS2_CLK low glitch of FILT_LEN-2 cycles in IDLE -> no state change. Asserting RST_N=0 mid-frame -> all outputs 0 immediately; the next full frame decodes.
